fetch_stage: RTL and testbench
==============================

# fetch_stage

- Instruction-fetch stage of the MIPS pipeline. Holds the PC and drives the instruction-memory address.
- Selects the next PC from PC+4, the branch target or the jump target.
- Captures the fetched word into the IF/ID pipeline register consumed by the decode stage, with stall (hold) and flush (bubble) control.
- The jump target is formed here from the decode stage's 26-bit index and the upper nibble of PC+4.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset; bits [1:0] must be 0.
- `NOP_WORD`, 32'h0000_0000, instruction word inserted into IF/ID on a bubble (`sll $0,$0,0`).
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `imem_addr` output 32: byte address to instruction memory; equals the PC register.
- `imem_rdata` input 32: instruction word at `imem_addr`; combinational read, same cycle.
- `stall` input 1: hold the PC and IF/ID contents (load-use hazard).
- `flush` input 1: load a bubble into IF/ID.
- `branch_taken` input 1: redirect the PC to `branch_target`.
- `branch_target` input 32: branch target byte address.
- `jump` input 1: redirect the PC to the jump target.
- `jump_index` input 26: `instr[25:0]` of the jump in decode.
- `if_id_instr` output 32: registered instruction.
- `if_id_pc4` output 32: registered PC+4 of that instruction.
- `if_id_valid` output 1: 1 = real instruction, 0 = bubble.
- `perf_fetch_cnt` output 32: only with `FETCH_PERF_EN`.
- `perf_bubble_cnt` output 32: only with `FETCH_PERF_EN`.

## Operation
- `pc4 = pc + 4`, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Jump target = `{if_id_pc4[31:28], jump_index, 2'b00}`. It uses the PC+4 of the jump instruction held in IF/ID, not the current PC.
- Branch target is used with bits [1:0] forced to 00. The PC is always word-aligned.
- `redirect = branch_taken | jump`.
- Next-PC priority, highest first:
  1. `!rst_n` → `RESET_PC`.
  2. `branch_taken` → branch target.
  3. `jump` → jump target.
  4. `stall` → hold.
  5. Otherwise → `pc4`.
- Redirect overrides stall. If `branch_taken` and `jump` are both asserted, the branch wins.
- IF/ID priority, highest first:
  1. `!rst_n` → instr = `NOP_WORD`, pc4 = 0, valid = 0.
  2. `flush | redirect` → instr = `NOP_WORD`, pc4 = 0, valid = 0. There is no delay slot: the word fetched in the redirect cycle is squashed internally.
  3. `stall` → hold all three fields.
  4. Otherwise → instr = `imem_rdata`, pc4 = `pc4`, valid = 1.
- Flush overrides stall.
- Stall with no redirect freezes the PC and IF/ID together, so the same word is re-fetched.

## Timing
- All state updates on the rising edge of `clk`. No asynchronous paths except `imem_addr` = PC register output.
- Reset values:
  - `imem_addr` = `RESET_PC`.
  - `if_id_instr` = `NOP_WORD`, `if_id_pc4` = 0, `if_id_valid` = 0.
  - Perf counters = 0.
- Reset held for N cycles: outputs stay at their reset values.
- First edge with `rst_n`=1: IF/ID captures the word at `RESET_PC`, and the PC becomes `RESET_PC`+4.
- Fetch latency: the word at PC in cycle n is on `if_id_instr` in cycle n+1.
- Redirect asserted in cycle n:
  - PC = target in cycle n+1.
  - IF/ID holds a bubble in cycle n+1.
  - The target word appears in IF/ID in cycle n+2.
  - Redirect penalty is exactly one bubble.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge. No pending redirect survives reset.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetch_cnt` increments on every non-reset edge where IF/ID loads with valid = 1.
  - `perf_bubble_cnt` increments on every non-reset edge where IF/ID loads a bubble.
  - Stall edges count in neither counter.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: both ports and their counters are absent. Remaining behaviour is identical.

## Test plan
- Reset then free-run, imem returning a word encoding its own address:
  - `imem_addr` sequence 0, 4, 8, 12.
  - `if_id_instr` one cycle behind.
  - `if_id_pc4` = 4, 8, 12.
  - valid goes 0 → 1 after the first edge with `rst_n`=1.
- `branch_taken`=1 with `branch_target`=32'h0000_0043 at PC=8:
  - Next PC = 32'h40.
  - IF/ID bubble for one cycle (valid = 0, instr = 0).
  - Then instr from 0x40 with pc4 = 0x44.
- `jump`=1, `jump_index`=26'h000_0010, IF/ID pc4 = 32'h1000_0008:
  - PC becomes 32'h1000_0040.
  - One bubble.
- `stall` for 3 cycles at PC=0x10:
  - PC stays 0x10 and IF/ID holds for 3 cycles.
  - `stall`+`flush` together: PC holds, IF/ID becomes a bubble.
  - `stall`+`branch_taken`: PC takes the target.
- With `RESET_PC`=32'hFFFF_FFF8: PC goes FFFF_FFF8 → FFFF_FFFC → 0000_0000.
  - Assert `rst_n`=0 mid-run: PC returns to FFFF_FFF8 on the next edge.
- `FETCH_PERF_EN` build, 10 free-run cycles with 1 redirect and 2 stall cycles:
  - `perf_fetch_cnt` = 7.
  - `perf_bubble_cnt` = 1.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the MIPS pipeline. Holds the PC, drives the
//   instruction-memory address, picks the next PC (PC+4 / branch / jump) and
//   captures the fetched word into the IF/ID pipeline register.
//
//   Optional feature macro: FETCH_PERF_EN (adds fetch / bubble counters).
//
// Parameters
//   RESET_PC   PC loaded by reset (word aligned)
//   NOP_WORD   instruction placed in IF/ID for a bubble
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   synchronous active-low reset
//   imem_addr        out  instruction-memory byte address (= PC register)
//   imem_rdata       in   instruction word at imem_addr (same cycle)
//   stall            in   hold PC and IF/ID
//   flush            in   load a bubble into IF/ID
//   branch_taken     in   redirect PC to branch_target
//   branch_target    in   branch target byte address
//   jump             in   redirect PC to the jump target
//   jump_index       in   instr[25:0] of the jump sitting in decode
//   if_id_instr      out  registered instruction
//   if_id_pc4        out  registered PC+4 of that instruction
//   if_id_valid      out  1 = real instruction, 0 = bubble
//   perf_fetch_cnt   out  valid IF/ID loads (FETCH_PERF_EN only)
//   perf_bubble_cnt  out  bubble IF/ID loads (FETCH_PERF_EN only)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt,
`endif
    output logic        if_id_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic        redirect;
    logic        bubble;

    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc4_q, ifpc4_d;
    logic        valid_q, valid_d;

    assign pc4         = pc_q + 32'd4;
    // Region bits come from the jump's own PC+4 (held in IF/ID), not the
    // current PC, which has already moved past the jump.
    assign jump_target = {ifpc4_q[31:28], jump_index, 2'b00};
    assign redirect    = branch_taken | jump;
    // No delay slot: whatever is fetched during a redirect is squashed.
    assign bubble      = flush | redirect;

    // Next PC: branch beats jump, any redirect beats stall.
    always_comb begin
        pc_d = pc4;
        if (branch_taken)
            pc_d = branch_target & 32'hFFFF_FFFC;
        else if (jump)
            pc_d = jump_target;
        else if (stall)
            pc_d = pc_q;
    end

    // IF/ID next state: bubble beats stall.
    always_comb begin
        instr_d = imem_rdata;
        ifpc4_d = pc4;
        valid_d = 1'b1;
        if (bubble) begin
            instr_d = NOP_WORD;
            ifpc4_d = 32'd0;
            valid_d = 1'b0;
        end else if (stall) begin
            instr_d = instr_q;
            ifpc4_d = ifpc4_q;
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            ifpc4_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = ifpc4_q;
    assign if_id_valid = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Stall edges (no bubble) count in neither counter.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bubble)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        else if (!stall)
            fetch_cnt_d = fetch_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: default RESET_PC
    logic        rst_n;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, flush, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    // DUT 2: RESET_PC near the top of the address space, free-running
    logic        rst2_n;
    logic [31:0] imem_addr2, imem_rdata2;
    logic [31:0] if_id_instr2, if_id_pc42;
    logic        if_id_valid2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt2, perf_bubble_cnt2;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // imem returns a word that encodes its own address (never equal to NOP)
    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hC000_0001;
    endfunction

    assign imem_rdata  = f(imem_addr);
    assign imem_rdata2 = f(imem_addr2);

    fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .if_id_valid(if_id_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
        .clk(clk), .rst_n(rst2_n),
        .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .stall(1'b0), .flush(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jump_index(26'h0),
        .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(perf_fetch_cnt2), .perf_bubble_cnt(perf_bubble_cnt2),
`endif
        .if_id_valid(if_id_valid2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // advance one edge; sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] p4,
                            input logic v);
        chk({tag, ".pc"},    imem_addr,   pc);
        chk({tag, ".instr"}, if_id_instr, ins);
        chk({tag, ".pc4"},   if_id_pc4,   p4);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    endtask

    task automatic idle();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 32'h0; jump_index = 26'h0;
    endtask

    initial begin
        idle();
        rst_n  = 0;
        rst2_n = 0;
        tick(); tick(); tick();
        chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst2.pc", imem_addr2, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
        chk("rst.pfetch",  perf_fetch_cnt,  32'd0);
        chk("rst.pbubble", perf_bubble_cnt, 32'd0);
`endif

        // free run
        rst_n = 1;
        chk("run0.pc", imem_addr, 32'h0);
        tick(); chk_ifid("run1", 32'h4, f(32'h0), 32'h4, 1'b1);
        tick(); chk_ifid("run2", 32'h8, f(32'h4), 32'h8, 1'b1);

        // branch at PC=8, target low bits forced to 00
        branch_taken = 1; branch_target = 32'h0000_0043;
        tick(); chk_ifid("br.bub", 32'h40, 32'h0, 32'h0, 1'b0);
        idle();
        tick(); chk_ifid("br.tgt", 32'h44, f(32'h40), 32'h44, 1'b1);

        // set up a jump sitting at 0x1000_0004 (IF/ID pc4 = 0x1000_0008)
        branch_taken = 1; branch_target = 32'h1000_0004;
        tick(); idle();
        tick(); chk_ifid("jsetup", 32'h1000_0008, f(32'h1000_0004), 32'h1000_0008, 1'b1);
        jump = 1; jump_index = 26'h000_0010;
        tick(); chk_ifid("jmp.bub", 32'h1000_0040, 32'h0, 32'h0, 1'b0);
        idle();
        tick(); chk_ifid("jmp.tgt", 32'h1000_0044, f(32'h1000_0040), 32'h1000_0044, 1'b1);

        // branch and jump together: branch wins
        branch_taken = 1; branch_target = 32'h200; jump = 1; jump_index = 26'h3;
        tick(); chk("brjmp.pc", imem_addr, 32'h200);
        idle();

        // get to PC=0x10 with 0xC's word in IF/ID
        branch_taken = 1; branch_target = 32'hC;
        tick(); idle();
        tick(); chk_ifid("stl.pre", 32'h10, f(32'hC), 32'h10, 1'b1);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_ifid($sformatf("stl%0d", i), 32'h10, f(32'hC), 32'h10, 1'b1);
        end
        flush = 1;
        tick(); chk_ifid("stl.flush", 32'h10, 32'h0, 32'h0, 1'b0);
        flush = 0; branch_taken = 1; branch_target = 32'h80;
        tick(); chk_ifid("stl.br", 32'h80, 32'h0, 32'h0, 1'b0);
        idle();
        tick(); chk_ifid("stl.after", 32'h84, f(32'h80), 32'h84, 1'b1);

        // flush alone: PC advances, bubble loaded
        flush = 1;
        tick(); chk_ifid("flush", 32'h88, 32'h0, 32'h0, 1'b0);
        idle();

        // reset mid-redirect: reset wins, nothing pending after
        branch_taken = 1; branch_target = 32'h400; rst_n = 0;
        tick(); chk_ifid("rstbr", 32'h0, 32'h0, 32'h0, 1'b0);
        idle(); rst_n = 1;
        tick(); chk_ifid("rstbr.rel", 32'h4, f(32'h0), 32'h4, 1'b1);

        // DUT 2 held in reset all along; now wrap test
        chk("rst2.hold.pc",    imem_addr2, 32'hFFFF_FFF8);
        chk("rst2.hold.valid", {31'd0, if_id_valid2}, 32'd0);
        rst2_n = 1;
        tick(); chk("wrap1.pc", imem_addr2, 32'hFFFF_FFFC);
                chk("wrap1.pc4", if_id_pc42, 32'hFFFF_FFFC);
                chk("wrap1.instr", if_id_instr2, f(32'hFFFF_FFF8));
        tick(); chk("wrap2.pc", imem_addr2, 32'h0);
                chk("wrap2.pc4", if_id_pc42, 32'h0);
                chk("wrap2.valid", {31'd0, if_id_valid2}, 32'd1);
        tick(); chk("wrap3.pc", imem_addr2, 32'h4);
        rst2_n = 0;
        tick(); chk("wrap.rst.pc", imem_addr2, 32'hFFFF_FFF8);
                chk("wrap.rst.valid", {31'd0, if_id_valid2}, 32'd0);

`ifdef FETCH_PERF_EN
        // 10 edges: 1 redirect, 2 stalls -> 7 fetches, 1 bubble
        idle(); rst_n = 0;
        tick();
        chk("perf.rst", perf_fetch_cnt, 32'd0);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i == 3) begin branch_taken = 1; branch_target = 32'h100; end
            if (i == 5 || i == 6) stall = 1;
            tick();
        end
        idle();
        chk("perf.fetch",  perf_fetch_cnt,  32'd7);
        chk("perf.bubble", perf_bubble_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
